// File: rtl/mc_controller.sv
// Multicycle CPU control FSM: Moore state register with combinational decode of state, op, zero and mem_ready.
// Instructions take 3-5 cycles; FETCH, MEMRD and MEMWR hold while mem_ready is low. Write enables are masked during reset.
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       irwrite,
  output logic       pcen,
  output logic       memwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  state_t cur;
  state_t nxt;

  logic pcwrite;
  logic branch;
  logic irwrite_raw;
  logic memwrite_raw;
  logic regwrite_raw;
  logic illegal_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur <= FETCH;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:   nxt = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = RTYPEEX;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = mem_ready ? MEMWB : MEMRD;
      MEMWR:   nxt = mem_ready ? FETCH : MEMWR;
      RTYPEEX: nxt = RTYPEWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    irwrite_raw  = 1'b0;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    case (cur)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_raw = 1'b0;
          default:                                       illegal_raw = 1'b1;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD: iord = 1'b1;
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: begin
        irwrite_raw = 1'b0;
      end
    endcase
  end

  // State already reads FETCH during reset, which would otherwise raise irwrite/pcen on mem_ready.
  assign irwrite  = reset_n & irwrite_raw;
  assign pcen     = reset_n & (pcwrite | (branch & zero));
  assign memwrite = reset_n & memwrite_raw;
  assign regwrite = reset_n & regwrite_raw;
  assign illegal  = reset_n & illegal_raw;
  assign state    = cur;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus randomized instruction stream against a path/stall reference model.
module tb_mc_controller;

  logic       clk;
  logic       reset_n;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       irwrite, pcen, memwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [3:0] state;
  logic       illegal;

  int tests = 0;
  int fails = 0;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
    .irwrite(irwrite), .pcen(pcen), .memwrite(memwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // Control word expected in a given state, straight from the per-state output table.
  function automatic logic [14:0] spec_ctl(input int s, input logic mr, input logic z, input logic bad);
    logic irw, pce, mw, rw, io, mtr, rd, sa, il;
    logic [1:0] sb, ps, ao;
    {irw, pce, mw, rw, io, mtr, rd, sa, il} = '0;
    sb = 2'b00; ps = 2'b00; ao = 2'b00;
    case (s)
      0:  begin sb = 2'b01; irw = mr; pce = mr; end
      1:  begin sb = 2'b11; il = bad; end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  io = 1'b1;
      4:  begin mtr = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; ao = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pce = z; end
      9:  begin sa = 1'b1; sb = 2'b10; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pce = 1'b1; end
      default: ;
    endcase
    return {irw, pce, mw, rw, io, mtr, rd, sa, sb, ps, ao, il};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    tests++;
    if (state !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    tests++;
    if ({irwrite, pcen, memwrite, regwrite, illegal} !== 5'b0) begin
      fails++; $display("FAIL reset_enables: got %b expected 00000", {irwrite, pcen, memwrite, regwrite, illegal});
    end
    reset_n = 1'b1;
    #1;
    tests++;
    if ({state, irwrite, pcen} !== {4'd0, 2'b11}) begin
      fails++; $display("FAIL release_fetch: got state %0d irwrite %b pcen %b expected 0 1 1", state, irwrite, pcen);
    end
    mem_ready = 1'b0;
    #1;
    tests++;
    if ({irwrite, pcen} !== 2'b00) begin fails++; $display("FAIL fetch_stall_en: got %b expected 00", {irwrite, pcen}); end
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd0) begin fails++; $display("FAIL fetch_hold: got %0d expected 0", state); end
  endtask

  task automatic test_lw();
    int es[6];
    es = '{0, 1, 2, 3, 4, 0};
    op = 6'b100011; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (state !== es[i][3:0]) begin fails++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++;
      if ({regwrite, memtoreg, aluop} !== {(es[i] == 4), (es[i] == 4), 2'b00}) begin
        fails++; $display("FAIL lw_ctl[%0d]: got %b expected %b", i, {regwrite, memtoreg, aluop}, {(es[i] == 4), (es[i] == 4), 2'b00});
      end
    end
  endtask

  task automatic test_rtype();
    int es[5];
    es = '{0, 1, 6, 7, 0};
    op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (state !== es[i][3:0]) begin fails++; $display("FAIL rtype_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++;
      if ({aluop, regdst, regwrite} !== {((es[i] == 6) ? 2'b10 : 2'b00), (es[i] == 7), (es[i] == 7)}) begin
        fails++; $display("FAIL rtype_ctl[%0d]: got %b state %0d", i, {aluop, regdst, regwrite}, es[i]);
      end
    end
  endtask

  task automatic test_beq(input logic z);
    int es[4];
    es = '{0, 1, 8, 0};
    op = 6'b000100; zero = z; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if (state !== es[i][3:0]) begin fails++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", z, i, state, es[i]); end
      if (es[i] == 8) begin
        tests++;
        if ({pcen, pcsrc} !== {z, 2'b01}) begin
          fails++; $display("FAIL beq%0d_branch: got pcen %b pcsrc %b expected %b 01", z, pcen, pcsrc, z);
        end
      end
    end
  endtask

  task automatic test_sw_stall();
    int   es[8];
    logic mrs[8];
    es  = '{0, 1, 2, 5, 5, 5, 5, 0};
    mrs = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    op = 6'b101011; zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      mem_ready = mrs[i];
      #1;
      tests++;
      if (state !== es[i][3:0]) begin fails++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, es[i]); end
      tests++;
      if ({memwrite, iord} !== {(es[i] == 5), (es[i] == 5)}) begin
        fails++; $display("FAIL sw_memwrite[%0d]: got %b expected %b", i, {memwrite, iord}, {(es[i] == 5), (es[i] == 5)});
      end
    end
  endtask

  task automatic test_illegal();
    int es[3];
    es = '{0, 1, 0};
    op = 6'b111111; zero = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      tests++;
      if ({state, illegal} !== {es[i][3:0], (es[i] == 1)}) begin
        fails++; $display("FAIL illegal[%0d]: got state %0d illegal %b expected %0d %b", i, state, illegal, es[i], (es[i] == 1));
      end
      if (es[i] == 1) begin
        tests++;
        if ({irwrite, pcen, memwrite, regwrite} !== 4'b0) begin
          fails++; $display("FAIL illegal_noen: got %b expected 0000", {irwrite, pcen, memwrite, regwrite});
        end
      end
    end
  endtask

  // Walk an instruction to target_state, then drop reset between edges.
  task automatic test_reset_mid(input logic [5:0] o, input int target);
    op = o; zero = 1'b1; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 8 && state !== target[3:0]; i++) begin
      @(negedge clk);
      mem_ready = (state == 4'd0 || state == 4'd1 || state == 4'd2);
      #1;
    end
    tests++;
    if (state !== target[3:0]) begin fails++; $display("FAIL rstmid_reach: got %0d expected %0d", state, target); end
    mem_ready = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    tests++;
    if ({state, irwrite, pcen, memwrite, regwrite, iord, illegal} !== 10'b0) begin
      fails++; $display("FAIL rstmid_%0d: got state %0d en %b expected 0 000000", target, state,
                        {irwrite, pcen, memwrite, regwrite, iord, illegal});
    end
    mem_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk); #1;
    tests++;
    if (state !== 4'd0) begin fails++; $display("FAIL rstmid_after_%0d: got %0d expected 0", target, state); end
  endtask

  task automatic test_random();
    int   path[$];
    int   idx, s, cycles, stalls, base;
    logic bad;
    logic [5:0] o;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0: o = 6'b100011;
        1: o = 6'b101011;
        2: o = 6'b000000;
        3: o = 6'b000100;
        4: o = 6'b001000;
        5: o = 6'b000010;
        default: o = 6'($urandom_range(0, 63));
      endcase
      bad = 1'b0;
      case (o)
        6'b100011: path = '{0, 1, 2, 3, 4};
        6'b101011: path = '{0, 1, 2, 5};
        6'b000000: path = '{0, 1, 6, 7};
        6'b000100: path = '{0, 1, 8};
        6'b001000: path = '{0, 1, 9, 10};
        6'b000010: path = '{0, 1, 11};
        default: begin path = '{0, 1}; bad = 1'b1; end
      endcase
      op = o;
      idx = 0; cycles = 0; stalls = 0;
      while (idx < path.size()) begin
        mem_ready = ($urandom_range(0, 3) != 0);
        zero = 1'($urandom_range(0, 1));
        #1;
        s = path[idx];
        tests++;
        if (state !== s[3:0]) begin fails++; $display("FAIL rnd_state op %b: got %0d expected %0d", o, state, s); end
        tests++;
        if ({irwrite, pcen, memwrite, regwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, illegal}
            !== spec_ctl(s, mem_ready, zero, bad)) begin
          fails++;
          $display("FAIL rnd_ctl op %b state %0d: got %b expected %b", o, s,
                   {irwrite, pcen, memwrite, regwrite, iord, memtoreg, regdst, alusrca, alusrcb, pcsrc, aluop, illegal},
                   spec_ctl(s, mem_ready, zero, bad));
        end
        cycles++;
        if ((s == 0 || s == 3 || s == 5) && !mem_ready) stalls++;
        else idx++;
        @(negedge clk);
      end
      base = (o == 6'b100011) ? 5 : (o == 6'b101011 || o == 6'b000000 || o == 6'b001000) ? 4 :
             (o == 6'b000100 || o == 6'b000010) ? 3 : 2;
      #1;
      tests++;
      if (state !== 4'd0 || cycles != base + stalls) begin
        fails++; $display("FAIL rnd_latency op %b: state %0d cycles %0d expected %0d", o, state, cycles, base + stalls);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; op = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_rtype();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw_stall();
    test_illegal();
    test_reset_mid(6'b100011, 3);
    test_reset_mid(6'b101011, 5);
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
